// File: rtl/shifter_pkg.sv
// Shared encodings for the parametrised shift/rotate unit: op codes,
// batch FSM states and a small op-classification helper.
package shifter_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_LSL  = 3'b010;
    localparam logic [2:0] OP_LSR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // True for the five ops that move bits (LSL, LSR, ASR, ROL, ROR).
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op >= OP_LSL) && (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational shift/rotate datapath. For shamt=0 the result equals the
// input; carry_out is only meaningful for a non-zero amount, so the owner
// of the carry register must gate its update on shamt != 0.
module shift_core
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]   data,
    input  logic [2:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               carry_out
);

    // WIDTH - shamt (mod WIDTH) and shamt - 1 (mod WIDTH): the bit positions
    // that leave the word last for left and right moves respectively.
    logic [SHAMT_W-1:0] neg_shamt;
    logic [SHAMT_W-1:0] lsb_idx;

    // Select the shifted/rotated word and the last bit moved out.
    always_comb begin
        neg_shamt = SHAMT_W'(0) - shamt;
        lsb_idx   = shamt - SHAMT_W'(1);
        result    = data;
        carry_out = 1'b0;
        case (op)
            OP_LSL: begin
                result    = data << shamt;
                carry_out = data[neg_shamt];
            end
            OP_LSR: begin
                result    = data >> shamt;
                carry_out = data[lsb_idx];
            end
            OP_ASR: begin
                result    = WIDTH'($signed(data) >>> shamt);
                carry_out = data[lsb_idx];
            end
            OP_ROL: begin
                // neg_shamt is 0 when shamt is 0, so both halves equal data.
                result    = (data << shamt) | (data >> neg_shamt);
                carry_out = data[neg_shamt];
            end
            OP_ROR: begin
                result    = (data >> shamt) | (data << neg_shamt);
                carry_out = data[lsb_idx];
            end
            default: begin
                result    = data;
                carry_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shifter_param.sv
// Registered WIDTH-bit shift/rotate unit with carry flag and a batch mode
// that repeats one latched shift 'count' times and then pulses done.
//
// Batch handshake: start is sampled only while busy=0 (state IDLE); the
// edge that samples it latches op/shamt/count and raises busy. busy stays
// high through RUN and the single DONE cycle; done is high for exactly
// that DONE cycle, after which busy drops on the same edge as done. Any
// start seen while busy=1 is dropped, not queued.
module shifter_param
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   d_in,
    input  logic               start,
    input  logic [CNT_W-1:0]   count,
    output logic [WIDTH-1:0]   d_out,
    output logic               carry,
    output logic               busy,
    output logic               done
);

    // FSM state is kept as a named enum so checkers can bind to it directly.
    state_t             state;
    logic [CNT_W-1:0]   cnt_rem;
    logic [2:0]         lat_op;
    logic [SHAMT_W-1:0] lat_shamt;

    logic [2:0]         core_op;
    logic [SHAMT_W-1:0] core_shamt;
    logic [WIDTH-1:0]   core_result;
    logic               core_carry;
    logic               apply_shift;

    // During RUN the core sees the latched command; otherwise the live inputs.
    always_comb begin
        core_op     = op;
        core_shamt  = shamt;
        if (state == RUN) begin
            core_op    = lat_op;
            core_shamt = lat_shamt;
        end
        apply_shift = is_shift_op(core_op) && (core_shamt != '0);
    end

    shift_core #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift_core (
        .data      (d_out),
        .op        (core_op),
        .shamt     (core_shamt),
        .result    (core_result),
        .carry_out (core_carry)
    );

    // Batch FSM, remaining-count counter and the data/carry/flag registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            d_out     <= '0;
            carry     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt_rem   <= '0;
            lat_op    <= OP_NOP;
            lat_shamt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Command capture edge: data is left untouched.
                        lat_op    <= op;
                        lat_shamt <= shamt;
                        cnt_rem   <= count;
                        busy      <= 1'b1;
                        if (is_shift_op(op) && (count != '0)) begin
                            state <= RUN;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else if (op == OP_LOAD) begin
                        d_out <= d_in;
                    end else if (apply_shift) begin
                        d_out <= core_result;
                        carry <= core_carry;
                    end
                end
                RUN: begin
                    if (apply_shift) begin
                        d_out <= core_result;
                        carry <= core_carry;
                    end
                    // cnt_rem is at least 1 here, so it cannot wrap.
                    cnt_rem <= cnt_rem - CNT_W'(1);
                    if (cnt_rem == CNT_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_param.sv
// Directed + randomised bench for shifter_param at WIDTH=32.
module tb_shifter_param;

    localparam int W  = 32;
    localparam int SW = 5;
    localparam int CW = 8;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] LSL  = 3'b010;
    localparam logic [2:0] LSR  = 3'b011;
    localparam logic [2:0] ASR  = 3'b100;
    localparam logic [2:0] ROL  = 3'b101;
    localparam logic [2:0] ROR  = 3'b110;
    localparam logic [2:0] RSVD = 3'b111;

    typedef struct packed {
        logic [W-1:0] d;
        logic         c;
        logic         b;
        logic         dn;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    op;
    logic [SW-1:0] shamt;
    logic [W-1:0]  d_in;
    logic          start;
    logic [CW-1:0] count;
    logic [W-1:0]  d_out;
    logic          carry;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    shifter_param #(.WIDTH(W), .SHAMT_W(SW), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .op      (op),
        .shamt   (shamt),
        .d_in    (d_in),
        .start   (start),
        .count   (count),
        .d_out   (d_out),
        .carry   (carry),
        .busy    (busy),
        .done    (done)
    );

    // ---------------- scoreboard ----------------
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push_exp(input logic [W-1:0] d, input logic c,
                            input logic b, input logic dn);
        exp_t e;
        e.d = d; e.c = c; e.b = b; e.dn = dn;
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        assert (d_out === e.d) else begin
            failures++;
            $error("FAIL %s d_out got=%h want=%h", tag, d_out, e.d);
        end
        checks++;
        assert (carry === e.c) else begin
            failures++;
            $error("FAIL %s carry got=%b want=%b", tag, carry, e.c);
        end
        checks++;
        assert (busy === e.b) else begin
            failures++;
            $error("FAIL %s busy got=%b want=%b", tag, busy, e.b);
        end
        checks++;
        assert (done === e.dn) else begin
            failures++;
            $error("FAIL %s done got=%b want=%b", tag, done, e.dn);
        end
    endtask

    // ---------------- driver ----------------
    // Drive one cycle's inputs (away from the edge), record the expected
    // post-edge outputs, then sample #1 after the rising edge.
    task automatic step(input string tag, input logic [2:0] o,
                        input logic [SW-1:0] s, input logic [W-1:0] di,
                        input logic st, input logic [CW-1:0] cn,
                        input logic [W-1:0] ed, input logic ec,
                        input logic eb, input logic edn);
        op = o; shamt = s; d_in = di; start = st; count = cn;
        push_exp(ed, ec, eb, edn);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    // Bit-by-bit reference for the free-running (IDLE, no start) case.
    // Returns {carry, data}.
    function automatic logic [W:0] ref_op(input logic [2:0] o,
                                          input logic [SW-1:0] s,
                                          input logic [W-1:0] d,
                                          input logic [W-1:0] di,
                                          input logic c);
        logic [W-1:0] r;
        logic         rc;
        int           si;
        si = int'(s);
        r  = d;
        rc = c;
        if (o == LOAD) begin
            r = di;
        end else if (o >= LSL && o <= ROR && si != 0) begin
            for (int i = 0; i < W; i++) begin
                case (o)
                    LSL: r[i] = (i >= si) ? d[i - si] : 1'b0;
                    LSR: r[i] = (i + si < W) ? d[i + si] : 1'b0;
                    ASR: r[i] = (i + si < W) ? d[i + si] : d[W-1];
                    ROL: r[i] = d[(i - si + W) % W];
                    default: r[i] = d[(i + si) % W];
                endcase
            end
            rc = (o == LSL || o == ROL) ? d[W - si] : d[si - 1];
        end
        return {rc, r};
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [W:0]   m;
        logic [W-1:0] md;
        logic         mc;
        logic [2:0]   ro;
        logic [SW-1:0] rs;
        logic [W-1:0] rd;

        reset_n = 1'b0;
        op = NOP; shamt = '0; d_in = '0; start = 1'b0; count = '0;
        @(negedge clk);
        step("reset", NOP, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        reset_n = 1'b1;

        // Free-running LSL.
        step("load0", LOAD, 0, 32'h0111_0111, 0, 0, 32'h0111_0111, 0, 0, 0);
        step("lsl1a", LSL, 1, 0, 0, 0, 32'h0222_0222, 0, 0, 0);
        step("lsl1b", LSL, 1, 0, 0, 0, 32'h0444_0444, 0, 0, 0);

        // Arithmetic and logical right shifts.
        step("load1", LOAD, 0, 32'h8000_0001, 0, 0, 32'h8000_0001, 0, 0, 0);
        step("asr4",  ASR, 4, 0, 0, 0, 32'hF800_0000, 0, 0, 0);
        step("lsr31", LSR, 31, 0, 0, 0, 32'h0000_0001, 1, 0, 0);

        // shamt=0 and NOP/reserved hold both data and carry.
        step("rol0",  ROL, 0, 0, 0, 0, 32'h0000_0001, 1, 0, 0);
        step("lsl0",  LSL, 0, 0, 0, 0, 32'h0000_0001, 1, 0, 0);
        step("nop",   NOP, 7, 32'hDEAD_BEEF, 0, 0, 32'h0000_0001, 1, 0, 0);
        step("rsvd",  RSVD, 3, 32'hDEAD_BEEF, 0, 0, 32'h0000_0001, 1, 0, 0);

        // LOAD keeps carry; rotates round-trip.
        step("load2", LOAD, 0, 32'h1234_5678, 0, 0, 32'h1234_5678, 1, 0, 0);
        step("ror8",  ROR, 8, 0, 0, 0, 32'h7812_3456, 0, 0, 0);
        step("rol8",  ROL, 8, 0, 0, 0, 32'h1234_5678, 0, 0, 0);
        step("asr0",  ASR, 0, 0, 0, 0, 32'h1234_5678, 0, 0, 0);

        // Batch LSL x5 with inputs toggled during RUN.
        step("load3", LOAD, 0, 32'h0000_0001, 0, 0, 32'h0000_0001, 0, 0, 0);
        step("b_start", LSL, 1, 0, 1, 5, 32'h0000_0001, 0, 1, 0);
        step("b_run1", LOAD, 3, 32'hFFFF_FFFF, 1, 9, 32'h0000_0002, 0, 1, 0);
        step("b_run2", ROR, 7, 32'hAAAA_AAAA, 0, 1, 32'h0000_0004, 0, 1, 0);
        step("b_run3", LOAD, 0, 32'h5555_5555, 1, 0, 32'h0000_0008, 0, 1, 0);
        step("b_run4", ASR, 2, 32'hFFFF_FFFF, 0, 3, 32'h0000_0010, 0, 1, 0);
        step("b_done", LOAD, 1, 32'hFFFF_FFFF, 1, 2, 32'h0000_0020, 0, 1, 1);
        // start during DONE is dropped.
        step("b_exit", LSL, 1, 0, 1, 3, 32'h0000_0020, 0, 0, 0);
        step("b_idle", NOP, 0, 0, 0, 0, 32'h0000_0020, 0, 0, 0);

        // count=0: straight to DONE, no shift; a start while busy is ignored.
        step("c0_start", LSL, 1, 0, 1, 0, 32'h0000_0020, 0, 1, 1);
        step("c0_exit",  LSL, 2, 0, 1, 4, 32'h0000_0020, 0, 0, 0);
        step("c0_idle",  NOP, 0, 0, 0, 0, 32'h0000_0020, 0, 0, 0);

        // start with LOAD: also straight to DONE, d_in not loaded.
        step("ld_start", LOAD, 0, 32'hDEAD_BEEF, 1, 7, 32'h0000_0020, 0, 1, 1);
        step("ld_exit",  LOAD, 0, 32'hDEAD_BEEF, 1, 7, 32'h0000_0020, 0, 0, 0);
        step("ld_idle",  NOP, 0, 0, 0, 0, 32'h0000_0020, 0, 0, 0);

        // Reset in the middle of a batch.
        step("load4", LOAD, 0, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 0, 0, 0);
        step("r_start", LSR, 1, 0, 1, 10, 32'hFFFF_FFFF, 0, 1, 0);
        step("r_run1", NOP, 0, 0, 0, 0, 32'h7FFF_FFFF, 1, 1, 0);
        step("r_run2", NOP, 0, 0, 0, 0, 32'h3FFF_FFFF, 1, 1, 0);
        reset_n = 1'b0;
        step("r_reset", NOP, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step("r_after", NOP, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        end

        // Random free-running ops against the bitwise reference.
        md = 32'h0;
        mc = 1'b0;
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            rs = SW'($urandom_range(0, W - 1));
            rd = $urandom();
            if (i % 6 == 0) ro = LOAD;
            m  = ref_op(ro, rs, md, rd, mc);
            md = m[W-1:0];
            mc = m[W];
            step("rand", ro, rs, rd, 0, 0, md, mc, 0, 0);
        end

        // A random batch checked against repeated application of the reference.
        step("rb_load", LOAD, 0, 32'hC3A5_0F96, 0, 0, 32'hC3A5_0F96, mc, 0, 0);
        md = 32'hC3A5_0F96;
        step("rb_start", ROR, 5, 0, 1, 4, md, mc, 1, 0);
        for (int i = 0; i < 4; i++) begin
            m  = ref_op(ROR, 5, md, 0, mc);
            md = m[W-1:0];
            mc = m[W];
            step("rb_run", LSL, 3, 32'h1111_1111, 1, 1, md, mc, 1, (i == 3));
        end
        step("rb_exit", NOP, 0, 0, 0, 0, md, mc, 0, 0);

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
